core_inst_sequencer: RTL
========================

Name: core_inst_sequencer

Overview:
Autonomous instruction generator for `core`. It drives the 17-bit `inst` word and the `mem_in` data bus through the full attention-psum flow: Q write, K write, K load, execute, and move from ofifo to pmem. Q and K vectors arrive on a valid/ready stream. The block replaces manual instruction driving and sits between the host data source and `core`.

Parameters:
- bw, 8, Q/K element bit width.
- pr, 8, elements per vector; `mem_in` width is pr*bw.
- col, 8, number of K vectors / dot-product units; must be 1..16.
- total_cycle, 8, number of Q vectors; must be 1..16.
- gap_cycles, 2, idle cycles after each memory-write phase.
- drain_cycles, 10, idle cycles after K load and after execute.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin one full sequence; sampled only in IDLE.
- in_data  in  pr*bw  Q or K vector, element j in bits [(j+1)*bw-1 : j*bw].
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts in_data this cycle.
- mem_in  out  pr*bw  registered data bus to `core`.
- inst  out  17  registered instruction to `core`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence end.

Behaviour:
- inst field map, decided:
  - [16] ofifo_rd
  - [15:12] qkmem_add
  - [11:8] pmem_add
  - [7] execute
  - [6] load
  - [5] qmem_rd
  - [4] qmem_wr
  - [3] kmem_rd
  - [2] kmem_wr
  - [1] pmem_rd
  - [0] pmem_wr
- Reset: state=IDLE; inst=0, mem_in=0, done=0, counters=0.
  - Reset is synchronous and overrides everything, including mid-sequence: outputs are zero after the next edge.
  - No partial-phase resume.
- All outputs except in_ready are registered. in_ready is decoded from registered state and count.
- States and transitions:
  - IDLE:
    - inst=0.
    - start=1 at an edge → QWR with count=0.
    - start while busy is ignored.
  - QWR:
    - in_ready=1.
    - On an edge with in_valid&in_ready: mem_in←in_data, inst←qmem_wr=1, qkmem_add=count; count increments.
    - Edge with in_valid=0: inst←0, mem_in holds its value, count holds.
    - Accept with count=total_cycle-1 → GAP1.
  - GAP1: inst=0 for gap_cycles cycles → KWR.
  - KWR: same rules as QWR but with kmem_wr, col beats → GAP2.
  - GAP2: inst=0 for gap_cycles cycles → KLOAD.
  - KLOAD: col+2 cycles, c=0..col+1.
    - load=1 throughout.
    - For c in 1..col: kmem_rd=1, qkmem_add=c-1.
    - Otherwise kmem_rd=0, qkmem_add=0.
    - Then → DRAIN1.
  - DRAIN1: inst=0 for drain_cycles cycles → EXEC.
  - EXEC: total_cycle cycles, q=0..total_cycle-1, execute=1, qmem_rd=1, qkmem_add=q → DRAIN2.
  - DRAIN2: inst=0 for drain_cycles cycles → MOVE.
  - MOVE: total_cycle cycles, ofifo_rd=1, pmem_wr=1, pmem_add=q → DONE.
  - DONE: inst=0, done=1 for one cycle → IDLE.
- in_ready=0 outside QWR/KWR. in_data is never consumed while not ready.
- Address fields are 4 bits, zero in every cycle where their enable is low.
- Only one of qmem/kmem/pmem rd/wr groups is active per cycle, as listed above.
- With in_valid held high, sequence length from start edge to DONE is total_cycle + gap + col + gap + (col+2) + drain + total_cycle + drain + total_cycle + 1. Defaults: 8+2+8+2+10+10+8+10+8+1 = 67 cycles.

Decomposition:
- Shared package core_inst_pkg holds:
  - inst bit-position localparams (OFIFO_RD=16, QKADD_MSB=15, QKADD_LSB=12, PADD_MSB=11, PADD_LSB=8, EXECUTE=7 … PMEM_WR=0);
  - INST_W=17, ADDR_W=4;
  - the state enum (IDLE, QWR, GAP1, KWR, GAP2, KLOAD, DRAIN1, EXEC, DRAIN2, MOVE, DONE).
- The `core` decoder and benches import the same package.
- One natural sub-module: seq_phase_counter, a loadable up-counter with a terminal-count flag. It is shared by all timed states and carries the 4-bit address index.

Test Plan:
- Defaults, start pulse, in_valid always high, Q=1..8, K=9..16 → inst[4]=1 on 8 consecutive cycles with qkmem_add 0..7 and mem_in matching; then 2 zero cycles; then kmem_wr with addr 0..7; done asserted exactly 67 cycles after the start edge.
- KLOAD window → load=1 for 10 cycles; kmem_rd=0 in first and last; addr 0..7 across middle 8 cycles; then inst=0 for 10 cycles.
- EXEC/MOVE → inst=0x000A0 with qkmem_add 0..7 for 8 cycles (inst[15:12]=q); after 10 idle cycles, ofifo_rd=1 and pmem_wr=1 with pmem_add 0..7 (inst=0x10001 | q<<8).
- in_valid toggled 1,0,1,0 during QWR → qmem_wr only on accepted beats; addresses contiguous 0..7 with no skips; mem_in held during bubbles.
- reset=1 for one cycle in the middle of EXEC → next edge inst=0, busy=0, done=0; a new start restarts from QWR at addr 0.
- start held high through the sequence, and total_cycle=1, col=1 build → no re-trigger while busy; minimum sequence 1+2+1+2+3+10+1+10+1+1 = 32 cycles.

Source files
------------

// File: rtl/core_inst_sequencer_pkg.sv
// Shared definitions for the core instruction word and the sequencer state machine.
// Imported by the sequencer, the core decoder and benches.
package core_inst_pkg;

  localparam int INST_W = 17;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;

  localparam int OFIFO_RD  = 16;
  localparam int QKADD_MSB = 15;
  localparam int QKADD_LSB = 12;
  localparam int PADD_MSB  = 11;
  localparam int PADD_LSB  = 8;
  localparam int EXECUTE   = 7;
  localparam int LOAD      = 6;
  localparam int QMEM_RD   = 5;
  localparam int QMEM_WR   = 4;
  localparam int KMEM_RD   = 3;
  localparam int KMEM_WR   = 2;
  localparam int PMEM_RD   = 1;
  localparam int PMEM_WR   = 0;

  typedef logic [3:0] state_t;

  localparam state_t IDLE   = 4'd0;
  localparam state_t QWR    = 4'd1;
  localparam state_t GAP1   = 4'd2;
  localparam state_t KWR    = 4'd3;
  localparam state_t GAP2   = 4'd4;
  localparam state_t KLOAD  = 4'd5;
  localparam state_t DRAIN1 = 4'd6;
  localparam state_t EXEC   = 4'd7;
  localparam state_t DRAIN2 = 4'd8;
  localparam state_t MOVE   = 4'd9;
  localparam state_t DONE   = 4'd10;

endpackage

// File: rtl/core_inst_sequencer_phase_counter.sv
// Loadable phase counter shared by every timed state; its low bits double as
// the memory address index for the current phase.
module seq_phase_counter
  import core_inst_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic [W-1:0]      last,
  output logic [W-1:0]      count,
  output logic [ADDR_W-1:0] idx,
  output logic              tc
);

  always_ff @(posedge clk) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + W'(1);
  end

  assign idx = count[ADDR_W-1:0];
  assign tc  = (count == last);

endmodule

// File: rtl/core_inst_sequencer.sv
// Autonomous instruction generator for core: Q write, K write, K load,
// execute, and ofifo-to-pmem move, with registered inst/mem_in outputs.
module core_inst_sequencer
  import core_inst_pkg::*;
#(
  parameter int bw           = 8,
  parameter int pr           = 8,
  parameter int col          = 8,
  parameter int total_cycle  = 8,
  parameter int gap_cycles   = 2,
  parameter int drain_cycles = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [pr*bw-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [pr*bw-1:0]    mem_in,
  output logic [INST_W-1:0]   inst,
  output logic                busy,
  output logic                done
);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, last;
  logic [ADDR_W-1:0]   idx;
  logic                tc, adv, clear;
  logic [INST_W-1:0]   inst_nx;

  assign in_ready = (state == QWR) || (state == KWR);
  assign busy     = (state != IDLE);

  // Write phases only step on accepted beats; every other busy state steps each cycle.
  assign adv   = in_ready ? in_valid : (state != IDLE);
  assign clear = (state == IDLE) || (adv && tc);

  seq_phase_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (adv),
    .last  (last),
    .count (cnt),
    .idx   (idx),
    .tc    (tc)
  );

  always_comb begin
    last = '0;
    case (state)
      QWR, EXEC, MOVE: last = CNT_W'(total_cycle - 1);
      KWR:             last = CNT_W'(col - 1);
      GAP1, GAP2:      last = CNT_W'(gap_cycles - 1);
      KLOAD:           last = CNT_W'(col + 1);
      DRAIN1, DRAIN2:  last = CNT_W'(drain_cycles - 1);
      default:         last = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (state == IDLE) begin
      if (start) state_nx = QWR;
    end else if (adv && tc) begin
      case (state)
        QWR:     state_nx = GAP1;
        GAP1:    state_nx = KWR;
        KWR:     state_nx = GAP2;
        GAP2:    state_nx = KLOAD;
        KLOAD:   state_nx = DRAIN1;
        DRAIN1:  state_nx = EXEC;
        EXEC:    state_nx = DRAIN2;
        DRAIN2:  state_nx = MOVE;
        MOVE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    inst_nx = '0;
    case (state)
      QWR: if (in_valid) begin
        inst_nx[QMEM_WR]             = 1'b1;
        inst_nx[QKADD_MSB:QKADD_LSB] = idx;
      end
      KWR: if (in_valid) begin
        inst_nx[KMEM_WR]             = 1'b1;
        inst_nx[QKADD_MSB:QKADD_LSB] = idx;
      end
      KLOAD: begin
        // One lead-in and one tail cycle bracket the col K reads.
        inst_nx[LOAD] = 1'b1;
        if (cnt != '0 && cnt <= CNT_W'(col)) begin
          inst_nx[KMEM_RD]             = 1'b1;
          inst_nx[QKADD_MSB:QKADD_LSB] = idx - ADDR_W'(1);
        end
      end
      EXEC: begin
        inst_nx[EXECUTE]             = 1'b1;
        inst_nx[QMEM_RD]             = 1'b1;
        inst_nx[QKADD_MSB:QKADD_LSB] = idx;
      end
      MOVE: begin
        inst_nx[OFIFO_RD]          = 1'b1;
        inst_nx[PMEM_WR]           = 1'b1;
        inst_nx[PADD_MSB:PADD_LSB] = idx;
      end
      default: inst_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      inst   <= '0;
      mem_in <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      inst  <= inst_nx;
      done  <= (state == DONE);
      if (in_ready && in_valid) mem_in <= in_data;
    end
  end

endmodule
